// File: rtl/alu_defs.sv
// Shared ALU definitions: result width, flag vector layout and the queued entry type.
package alu_defs;

  localparam int unsigned RESULT_W = 16;
  localparam int unsigned FLAG_W   = 3;
  localparam int unsigned FLAG_C   = 2;
  localparam int unsigned FLAG_N   = 1;
  localparam int unsigned FLAG_Z   = 0;

  typedef struct packed {
    logic [RESULT_W-1:0] sum;
    logic [FLAG_W-1:0]   flags;
  } entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status-flag derivation {C, N, Z} from an 8-bit-datapath result.
module alu_flag_gen
  import alu_defs::*;
(
  input  logic [RESULT_W-1:0] sum_i,
  output logic [FLAG_W-1:0]   flags_o
);

  always_comb begin
    flags_o         = '0;
    flags_o[FLAG_C] = sum_i[8];
    flags_o[FLAG_N] = sum_i[7];
    flags_o[FLAG_Z] = (sum_i[7:0] == 8'h00);
  end

endmodule

// File: rtl/alu_result_queue.sv
// Captures adder results on done pulses, tags them with flags and queues them for a
// valid/ready consumer; results arriving while full are dropped and flagged.
module alu_result_queue
  import alu_defs::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_done,
  input  logic [RESULT_W-1:0]        in_sum,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RESULT_W-1:0]        out_sum,
  output logic [FLAG_W-1:0]          out_flags,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       drop_err,
  input  logic                       clear_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              drop_err_q, drop_err_d;
  logic [FLAG_W-1:0] in_flags;
  logic              push, pop, drop;

  alu_flag_gen u_flag_gen (
    .sum_i   (in_sum),
    .flags_o (in_flags)
  );

  always_comb begin
    out_valid = (count_q != '0);
    full      = (count_q == CntW'(DEPTH));
    pop       = out_valid && out_ready;
    // A full queue still accepts a push when the head leaves in the same cycle.
    push      = in_done && (!full || pop);
    drop      = in_done && full && !pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q].sum   = in_sum;
      mem_d[wr_ptr_q].flags = in_flags;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    // Set has priority over clear.
    if (drop) begin
      drop_err_d = 1'b1;
    end else if (clear_err) begin
      drop_err_d = 1'b0;
    end else begin
      drop_err_d = drop_err_q;
    end

    out_sum   = out_valid ? mem_q[rd_ptr_q].sum   : '0;
    out_flags = out_valid ? mem_q[rd_ptr_q].flags : '0;
    count     = count_q;
    drop_err  = drop_err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_err_q <= drop_err_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: doc/alu_result_queue.md
# alu_result_queue

Result-capture stage directly downstream of the 8-bit adder. It samples the adder's 16-bit `sum` on every one-cycle `done` pulse, derives the status flags (carry, negative, zero) and queues result-plus-flags in a small FIFO. A consumer (register file write-back or the top-level ALU output port) drains the FIFO through a valid/ready handshake. The adder has no back-pressure, so a result arriving while the queue is full is dropped and flagged.

## Interface
- `DEPTH`, default 4: number of queue entries; power of two, at least 2.
- `clk`  input  1: clock; all state updates on the rising edge.
- `reset`  input  1: synchronous, active-high reset; flushes the queue.
- `in_done`  input  1: one-cycle pulse from the adder; qualifies `in_sum`.
- `in_sum`  input  16: adder result; bit 8 is carry-out; bits 15:8 are copies of the carry.
- `out_valid`  output  1: head entry present.
- `out_ready`  input  1: consumer accepts the head entry when high together with `out_valid`.
- `out_sum`  output  16: head entry sum; 0 when the queue is empty.
- `out_flags`  output  3: head entry flags {C, N, Z}; 0 when the queue is empty.
- `count`  output  clog2(DEPTH)+1: number of occupied entries.
- `full`  output  1: `count == DEPTH`.
- `drop_err`  output  1: sticky; set when a result is dropped.
- `clear_err`  input  1: clears `drop_err`.

## Operation
- Flag derivation happens at push time and is stored with the entry:
  - C = `in_sum[8]`.
  - N = `in_sum[7]`.
  - Z = (`in_sum[7:0]` == 0).
- Push: occurs when `in_done` is high and the queue is not full, or when it is full and a pop happens in the same cycle.
- Pop: occurs when `out_valid && out_ready`; the head pointer advances.
- Simultaneous push and pop: `count` is unchanged; both pointers advance.
- Empty: `out_valid` is 0, so no pop is possible.
  - There is no bypass: a push into an empty queue becomes visible the next cycle.
- Full with `in_done` and no pop: the entry is discarded, `drop_err` is set, and queue contents are unchanged.
- `clear_err` and a drop in the same cycle: the set wins, and `drop_err` stays 1.
- Pointers are clog2(DEPTH) bits wide and wrap modulo DEPTH; `count` disambiguates full from empty.
- `out_ready` high while empty has no effect.
- `in_sum` is ignored whenever `in_done` is low.

## Timing
- Reset values:
  - `out_valid`=0, `out_sum`=0, `out_flags`=0.
  - `count`=0, `full`=0, `drop_err`=0.
  - Pointers are 0.
  - Storage contents are don't-care.
- Reset mid-operation: all queued entries are lost, and an `in_done` in the reset cycle is ignored.
- Latency: a push at edge N makes `out_valid` = 1 after edge N, with that entry at the head if the queue was empty.
- Outputs are registered or driven from the head storage entry; there is no combinational path from `in_*` to `out_*`.
- `out_sum` and `out_flags` are stable while `out_valid` is high and `out_ready` is low.
- Throughput: one push and one pop per cycle sustained. The adder produces at most one `done` every 4 cycles.

## Structure
- Shared package or include `alu_defs`:
  - flag bit indices FLAG_C=2, FLAG_N=1, FLAG_Z=0;
  - flag vector width 3;
  - the result width 16.
- Sub-module `alu_flag_gen`: purely combinational, 16-bit sum in, 3-bit flags out. It is reused later by the subtract/logic units.
- The FIFO storage, pointers and counter live in this module.

## Test plan
- Adder 100 + 27 (`in_sum`=0x007F, one pulse) -> next cycle `out_valid`=1, `out_sum`=0x007F, `out_flags`=3'b000; pop with `out_ready`=1 -> `out_valid`=0, `count`=0.
- 1 + (-1) (`in_sum`=0xFF00) and -128 + -128 (`in_sum`=0xFF00) -> each entry reads `out_flags`=3'b101 (C=1, N=0, Z=1).
- 0x40 + 0x40 (`in_sum`=0x0080) -> `out_flags`=3'b010.
- Five pushes with `out_ready`=0 and DEPTH=4 -> `full`=1 after the 4th, 5th dropped, `drop_err`=1; drain yields the first four sums in order, and `drop_err` stays 1 until a `clear_err` pulse.
- Queue full, `in_done` and `out_ready` in the same cycle -> `count` stays 4, no drop, new sum appears last on drain; wrap-around verified over 10 entries.
- `reset` asserted with 3 entries queued and `in_done` high -> next cycle `count`=0, `out_valid`=0, `out_sum`=0, `drop_err`=0.
